// File: rtl/rr_merge_pkg.sv
// ---------------------------------------------------------------------------
// rr_merge_pkg
// Shared types for the two-input round-robin merge stage.
//   occ_state_e    : occupancy of the 2-entry output skid buffer
//   src_e          : identifies an upstream port (A or B)
//   RST_LAST_GRANT : arbiter history after reset; B, so A wins the first
//                    contention
// ---------------------------------------------------------------------------
package rr_merge_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } occ_state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    localparam src_e RST_LAST_GRANT = SRC_B;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. It remembers which port was last
// accepted and hands contention to the other one.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_a, req_b    : requests (upstream valids)
//   accept          : the granted request was actually transferred this cycle
//   gnt_a, gnt_b    : one-hot (or zero) grant
//   gnt_src         : encoded grant, SRC_A when nothing is granted
// ---------------------------------------------------------------------------
module rr_arb2
    import rr_merge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic gnt_a,
    output logic gnt_b,
    output src_e gnt_src
);

    src_e last_grant_q;
    src_e last_grant_d;

    // Grant decode. A lone requester always wins; under contention the port
    // that did not win last time is chosen. This depends only on the requests
    // and the history flop, never on downstream state.
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        gnt_src = SRC_A;
        if (req_a && req_b) begin
            if (last_grant_q == SRC_B) begin
                gnt_a   = 1'b1;
                gnt_src = SRC_A;
            end else begin
                gnt_b   = 1'b1;
                gnt_src = SRC_B;
            end
        end else if (req_a) begin
            gnt_a   = 1'b1;
            gnt_src = SRC_A;
        end else if (req_b) begin
            gnt_b   = 1'b1;
            gnt_src = SRC_B;
        end
    end

    // History update is kept in its own block: accept is derived from the
    // grant outside this module, so mixing the two would form a false loop.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = gnt_src;
        end
    end

    // History register; only a real transfer moves it, so a grant that was
    // blocked by a full buffer does not cost that port its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= RST_LAST_GRANT;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rr_merge_2to1.sv
// ---------------------------------------------------------------------------
// rr_merge_2to1
// Merges two valid/ready streams into one with round-robin fairness. Accepted
// words go into a 2-entry (head + skid) output buffer so that every
// downstream-facing output comes straight from a flop and upstream ready
// never depends on down_ready.
// Optional feature macro: RR_MERGE_SRC_TAG_EN adds down_src, telling which
// port (0 = A, 1 = B) each output word came from.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   up_data_a/up_valid_a/up_ready_a : upstream port A
//   up_data_b/up_valid_b/up_ready_b : upstream port B
//   down_data/down_valid/down_ready : merged output (data/valid registered)
//   down_src                        : source tag (RR_MERGE_SRC_TAG_EN only)
// ---------------------------------------------------------------------------
module rr_merge_2to1
    import rr_merge_pkg::*;
#(
    parameter int D_WIDTH = 6
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data_a,
    input  logic               up_valid_a,
    output logic               up_ready_a,
    input  logic [D_WIDTH-1:0] up_data_b,
    input  logic               up_valid_b,
    output logic               up_ready_b,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready
`ifdef RR_MERGE_SRC_TAG_EN
    ,
    output logic               down_src
`endif
);

`ifdef RR_MERGE_SRC_TAG_EN
    localparam int E_WIDTH = D_WIDTH + 1;
`else
    localparam int E_WIDTH = D_WIDTH;
`endif

    occ_state_e         state_q;
    occ_state_e         state_d;
    logic [E_WIDTH-1:0] head_q;
    logic [E_WIDTH-1:0] head_d;
    logic [E_WIDTH-1:0] skid_q;
    logic [E_WIDTH-1:0] skid_d;
    logic               valid_q;
    logic               valid_d;

    logic               space;
    logic               gnt_a;
    logic               gnt_b;
    src_e               gnt_src;
    logic               push;
    logic               pop;
    logic [D_WIDTH-1:0] push_data;
    logic [E_WIDTH-1:0] push_entry;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (up_valid_a),
        .req_b   (up_valid_b),
        .accept  (push),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .gnt_src (gnt_src)
    );

    // Handshake glue. Space comes from the registered occupancy only, which
    // is what keeps down_ready out of the upstream ready path; the cost is
    // that a full buffer stalls for one cycle even if it is being drained.
    always_comb begin
        space      = (state_q != ST_TWO);
        up_ready_a = space && gnt_a;
        up_ready_b = space && gnt_b;
        push       = space && (gnt_a || gnt_b);
        pop        = valid_q && down_ready;
        push_data  = (gnt_src == SRC_B) ? up_data_b : up_data_a;
`ifdef RR_MERGE_SRC_TAG_EN
        push_entry = {gnt_src, push_data};
`else
        push_entry = push_data;
`endif
    end

    // Occupancy FSM and buffer steering. The head always holds the oldest
    // word; a push that coincides with a pop in ST_ONE overwrites the head
    // directly so the output never shows a bubble.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = push_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = push_entry;
                end else if (push) begin
                    skid_d  = push_entry;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        valid_d = (state_d != ST_EMPTY);
    end

    // State and storage registers. down_valid has its own flop so the output
    // is a clean register rather than a decode of the state bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
        end
    end

    assign down_valid = valid_q;
    assign down_data  = head_q[D_WIDTH-1:0];
`ifdef RR_MERGE_SRC_TAG_EN
    assign down_src   = head_q[D_WIDTH];
`endif

endmodule

// File: tb/tb_rr_merge_2to1.sv
// ---------------------------------------------------------------------------
// tb_rr_merge_2to1
// Bench for rr_merge_2to1. A queue-based reference of the merge (a list of at
// most two pending output words plus the last accepted port) predicts the
// outputs every cycle; directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_rr_merge_2to1;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] up_data_a = '0;
    logic          up_valid_a = 1'b0;
    logic          up_ready_a;
    logic [DW-1:0] up_data_b = '0;
    logic          up_valid_b = 1'b0;
    logic          up_ready_b;
    logic [DW-1:0] down_data;
    logic          down_valid;
    logic          down_ready = 1'b1;
`ifdef RR_MERGE_SRC_TAG_EN
    logic          down_src;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: pending output words as {src, data}, oldest first.
    logic [DW:0] mq[$];
    bit          m_last_b = 1'b1;
    bit          acc_a = 1'b0;
    bit          acc_b = 1'b0;

    always #5 clk = ~clk;

    rr_merge_2to1 #(.D_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data_a  (up_data_a),
        .up_valid_a (up_valid_a),
        .up_ready_a (up_ready_a),
        .up_data_b  (up_data_b),
        .up_valid_b (up_valid_b),
        .up_ready_b (up_ready_b),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready)
`ifdef RR_MERGE_SRC_TAG_EN
        ,
        .down_src   (down_src)
`endif
    );

    // A port may take a word when fewer than two are pending and it is the
    // lone requester, or it is the requester that did not win last time.
    function automatic bit expReadyA();
        if (mq.size() >= 2 || !up_valid_a) return 1'b0;
        if (up_valid_b) return m_last_b;
        return 1'b1;
    endfunction

    function automatic bit expReadyB();
        if (mq.size() >= 2 || !up_valid_b) return 1'b0;
        if (up_valid_a) return !m_last_b;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference update on each rising edge: pop the oldest word if the
    // consumer took it, then append whatever port was accepted.
    always @(posedge clk) begin
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (rst) begin
            mq.delete();
            m_last_b = 1'b1;
        end else begin
            acc_a = expReadyA();
            acc_b = expReadyB();
            if (mq.size() > 0 && down_ready) void'(mq.pop_front());
            if (acc_a) begin
                mq.push_back({1'b0, up_data_a});
                m_last_b = 1'b0;
            end
            if (acc_b) begin
                mq.push_back({1'b1, up_data_b});
                m_last_b = 1'b1;
            end
        end
    end

    // Every cycle out of reset, compare all outputs against the reference.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("up_ready_a", up_ready_a, expReadyA());
            checkOutput("up_ready_b", up_ready_b, expReadyB());
            checkOutput("down_valid", down_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                checkOutput("down_data", down_data, mq[0][DW-1:0]);
`ifdef RR_MERGE_SRC_TAG_EN
                checkOutput("down_src", down_src, mq[0][DW]);
`endif
            end
        end
    end

    // Advance one edge; a source drops valid once its word was taken.
    task automatic step();
        @(posedge clk);
        #1;
        if (acc_a) up_valid_a = 1'b0;
        if (acc_b) up_valid_b = 1'b0;
    endtask

    // Offer a new word on a port only if that port is idle.
    task automatic applyStimulus(input bit load_a, input logic [DW-1:0] da,
                                 input bit load_b, input logic [DW-1:0] db);
        if (load_a && !up_valid_a) begin
            up_valid_a = 1'b1;
            up_data_a  = da;
        end
        if (load_b && !up_valid_b) begin
            up_valid_b = 1'b1;
            up_data_b  = db;
        end
    endtask

    task automatic doReset();
        up_valid_a = 1'b0;
        up_valid_b = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        doReset();

        // Reset state, then a single word on A.
        @(negedge clk);
        checkOutput("rst_down_valid", down_valid, 0);
        checkOutput("rst_down_data", down_data, 0);
        checkOutput("rst_ready_a_idle", up_ready_a, 0);
        step();
        applyStimulus(1, 6'h05, 0, 6'h00);
        @(negedge clk);
        checkOutput("single_ready_a", up_ready_a, 1);
        checkOutput("single_pre_valid", down_valid, 0);
        step();
        @(negedge clk);
        checkOutput("single_valid", down_valid, 1);
        checkOutput("single_data", down_data, 6'h05);
`ifdef RR_MERGE_SRC_TAG_EN
        checkOutput("single_src", down_src, 0);
`endif

        // Continuous contention with an always-ready consumer.
        doReset();
        applyStimulus(1, 6'h11, 1, 6'h22);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("alt_ready_a", up_ready_a, (i % 2) == 0);
            checkOutput("alt_ready_b", up_ready_b, (i % 2) == 1);
            if (i > 0) begin
                checkOutput("alt_valid", down_valid, 1);
                checkOutput("alt_data", down_data, ((i % 2) == 1) ? 6'h11 : 6'h22);
            end
            step();
            applyStimulus(1, 6'h11, 1, 6'h22);
        end

        // Back-pressure: two words taken, then a stall, then drain.
        doReset();
        down_ready = 1'b0;
        applyStimulus(1, 6'h11, 1, 6'h22);
        @(negedge clk);
        checkOutput("bp0_ready_a", up_ready_a, 1);
        checkOutput("bp0_valid", down_valid, 0);
        step();
        applyStimulus(1, 6'h11, 1, 6'h22);
        @(negedge clk);
        checkOutput("bp1_ready_b", up_ready_b, 1);
        checkOutput("bp1_data", down_data, 6'h11);
        step();
        applyStimulus(1, 6'h11, 1, 6'h22);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("bp_full_ready_a", up_ready_a, 0);
            checkOutput("bp_full_ready_b", up_ready_b, 0);
            checkOutput("bp_hold_data", down_data, 6'h11);
            step();
        end
        down_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_rel_ready_a", up_ready_a, 0);
        checkOutput("bp_rel_data", down_data, 6'h11);
        step();
        applyStimulus(1, 6'h11, 1, 6'h22);
        @(negedge clk);
        checkOutput("bp_drain_data", down_data, 6'h22);
        checkOutput("bp_drain_ready_a", up_ready_a, 1);
        step();
        applyStimulus(1, 6'h11, 1, 6'h22);
        @(negedge clk);
        checkOutput("bp_resume_data", down_data, 6'h11);
        checkOutput("bp_resume_ready_b", up_ready_b, 1);

        // B alone for four words, then A joins and wins the contention.
        doReset();
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(0, 6'h00, 1, 6'(j));
            @(negedge clk);
            checkOutput("bonly_ready_b", up_ready_b, 1);
            if (j > 1) checkOutput("bonly_data", down_data, j - 1);
            step();
        end
        applyStimulus(1, 6'h0A, 1, 6'h05);
        @(negedge clk);
        checkOutput("join_data", down_data, 6'h04);
        checkOutput("join_ready_a", up_ready_a, 1);
        checkOutput("join_ready_b", up_ready_b, 0);
        step();
        @(negedge clk);
        checkOutput("join_next_data", down_data, 6'h0A);
        checkOutput("join_next_ready_b", up_ready_b, 1);
        step();

        // Reset while the buffer is full.
        doReset();
        down_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 6'h15, 1, 6'h2A);
            step();
        end
        applyStimulus(1, 6'h15, 1, 6'h2A);
        @(negedge clk);
        checkOutput("full_before_rst", up_ready_a | up_ready_b, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst2_valid", down_valid, 0);
        checkOutput("rst2_ready_a", up_ready_a, 1);
        checkOutput("rst2_ready_b", up_ready_b, 0);
        step();

        // Random traffic with varying consumer pressure and rare resets.
        down_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            int pct;
            step();
            pct = ((i / 1000) % 3 == 0) ? 90 : (((i / 1000) % 3 == 1) ? 50 : 20);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 799) == 0) rst = 1'b1;
            applyStimulus($urandom_range(0, 3) != 0, 6'($urandom),
                          $urandom_range(0, 3) != 0, 6'($urandom));
            down_ready = ($urandom_range(0, 99) < pct);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_merge_2to1.md
# rr_merge_2to1

Two-input round-robin merge stage that recombines the two streams produced by the fork path (down_a / down_b FIFO outputs) into a single valid/ready stream. It arbitrates fairly between the two upstream ports and buffers one transfer per cycle through a 2-entry output skid buffer, so all downstream-facing outputs are registered. Data is passed unmodified. With the optional source tag, each output word is labelled with its originating port.

## Interface
- D_WIDTH, default 6: data width of both inputs and the output.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- up_data_a  input  D_WIDTH  port A data.
- up_valid_a  input  1  port A valid.
- up_ready_a  output  1  port A ready.
- up_data_b  input  D_WIDTH  port B data.
- up_valid_b  input  1  port B valid.
- up_ready_b  output  1  port B ready.
- down_data  output  D_WIDTH  merged data, registered.
- down_valid  output  1  merged valid, registered.
- down_ready  input  1  downstream ready.
- down_src  output  1  source tag, 0 = A, 1 = B, registered. Present only with RR_MERGE_SRC_TAG_EN.

## Operation
- Transfer on any port occurs when valid && ready are high at a rising edge.
- Output buffer has two entries, head and skid. Its occupancy FSM has three states:
  - ST_EMPTY: push moves to ST_ONE.
  - ST_ONE: push with pop stays in ST_ONE; push alone moves to ST_TWO; pop alone moves to ST_EMPTY.
  - ST_TWO: pop moves to ST_ONE; no push is possible.
- space = (state != ST_TWO). This is derived from registered state only.
- Arbitration:
  - Only one valid: grant that port.
  - Both valid: grant the port not in last_grant.
  - Neither valid: no grant.
- up_ready_x = space && grant_x. At most one up_ready is high per cycle.
- Ready may depend on valid. Valid never depends on ready.
- last_grant updates only on an accepted upstream transfer, to the accepted port.
- down_data / down_valid always reflect the head entry. On a pop in ST_TWO, the skid entry moves to head.
- Ordering: per-port order is preserved. Cross-port order follows grant order.
- Reset values:
  - State ST_EMPTY.
  - down_valid 0.
  - down_data 0.
  - down_src 0.
  - last_grant = B, so A wins the first contention.
  - up_ready_a / up_ready_b follow valid, because space = 1.
- Reset mid-operation: buffered words are discarded. Upstream words not yet accepted are unaffected.

## Timing
- Latency: accept at edge N gives down_valid high after edge N, with data visible in cycle N+1, when the buffer was empty or popping.
- Throughput: 1 word/cycle sustained while down_ready = 1.
- Both ports valid continuously with down_ready = 1: grants alternate A, B, A, B… every cycle.
- down_ready deasserted: at most two more words are accepted (ST_ONE, then ST_TWO), after which both up_ready drop in the following cycle.
- Push and pop in ST_ONE on the same edge: the head is replaced by the new word and down_valid stays 1 with no bubble.
- down_data is held stable while down_valid && !down_ready.
- up_ready_x has a combinational path from up_valid_a/b and last_grant only. There is no combinational path from down_ready.

## Configuration
- RR_MERGE_SRC_TAG_EN defined:
  - down_src port exists.
  - Each buffer entry stores {src, data}, with width D_WIDTH+1.
  - src = granted port at push time.
- RR_MERGE_SRC_TAG_EN undefined:
  - down_src port is absent.
  - Entries store data only.
  - Arbitration and timing are identical.

## Structure
- Package rr_merge_pkg contains:
  - typedef enum logic [1:0] occ_state_e {ST_EMPTY, ST_ONE, ST_TWO}.
  - typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e.
  - localparam src_e RST_LAST_GRANT = SRC_B.
- Sub-module rr_arb2 holds the last_grant register and grant logic.
  - Inputs: clk, rst, req_a, req_b, accept.
  - Outputs: gnt_a, gnt_b, gnt_src.
- The top level holds the occupancy FSM and the head/skid registers.

## Test plan
- Reset, then A sends 0x05 with B idle -> down_data = 0x05 and down_valid = 1 one cycle later; down_src = 0 with tag enabled.
- A and B valid together, A = 0x11 and B = 0x22 continuous, down_ready = 1 -> output 0x11, 0x22, 0x11, 0x22… with no bubbles and up_ready alternating.
- Back-pressure: down_ready = 0 with both valid -> exactly two words accepted, both up_ready = 0 from the third cycle, and down_data held. Then release down_ready -> buffered words drain in order, then streaming resumes with no loss or duplication.
- Only B valid for 4 cycles (0x01–0x04), then A joins -> B's words appear in order; the next contention grants A (last_grant = B).
- rst asserted while in ST_TWO -> next cycle down_valid = 0 and state ST_EMPTY; the first post-reset contention grants A.
- Random valid/ready on all ports for 10k cycles, with a scoreboard per source -> per-port order preserved, no drops, and the grant gap never exceeds 1 under contention.
